// File: rtl/stream_sync_fifo_if.sv
// Stream FIFO handshake bundle: sender side, receiver side and status.
// slave = FIFO view, master = producer/consumer view.
interface stream_sync_fifo_if #(
  parameter int DEPTH      = 144,
  parameter int DATA_WIDTH = 256
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  sender_valid_in;
  logic                  sender_last_in;
  logic [DATA_WIDTH-1:0] sender_data_in;
  logic                  fifo_ready_out;
  logic                  receiver_ready_in;
  logic                  receiver_valid_out;
  logic [DATA_WIDTH-1:0] receiver_data_out;
  logic                  receiver_last_out;
  logic [CW-1:0]         count_out;
  logic                  almost_full_out;

  modport slave (
    input  sender_valid_in,
    input  sender_last_in,
    input  sender_data_in,
    output fifo_ready_out,
    input  receiver_ready_in,
    output receiver_valid_out,
    output receiver_data_out,
    output receiver_last_out,
    output count_out,
    output almost_full_out
  );

  modport master (
    output sender_valid_in,
    output sender_last_in,
    output sender_data_in,
    input  fifo_ready_out,
    output receiver_ready_in,
    input  receiver_valid_out,
    input  receiver_data_out,
    input  receiver_last_out,
    input  count_out,
    input  almost_full_out
  );
endinterface

// File: rtl/stream_sync_fifo.sv
// Single-clock show-ahead stream FIFO, any DEPTH >= 2, with last flag.
// STREAM_FIFO_STORE_FWD_EN holds beats back until a whole packet is stored.
module stream_sync_fifo #(
  parameter int DEPTH       = 144,
  parameter int DATA_WIDTH  = 256,
  parameter int AFULL_LEVEL = DEPTH - 4
) (
  input  logic                clk_pixel,
  input  logic                rst_in,
  stream_sync_fifo_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_LEVEL);

  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          afull;
  logic          ready;
  logic          valid;
  logic          push;
  logic          pop;
  logic          head_last;
  logic [DATA_WIDTH-1:0] head_data;

  // ready depends on registered state only, never on sender valid
  assign ready = !rst_in && (count < FULL_CNT);
  assign push  = bus.sender_valid_in && ready;
  assign pop   = valid && bus.receiver_ready_in;

  assign wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_nxt = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      afull  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr_nxt;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      count <= count_nxt;
      afull <= (count_nxt >= AF_CNT);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_ptr] <= {bus.sender_data_in, bus.sender_last_in};
  end

  assign {head_data, head_last} = mem[rd_ptr];

`ifdef STREAM_FIFO_STORE_FWD_EN
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] pkt_cnt_nxt;
  logic          pkt_in;
  logic          pkt_out;

  assign pkt_in  = push && bus.sender_last_in;
  assign pkt_out = pop && head_last;

  always_comb begin
    pkt_cnt_nxt = pkt_cnt;
    unique case ({pkt_in, pkt_out})
      2'b10:   pkt_cnt_nxt = pkt_cnt + 1'b1;
      2'b01:   pkt_cnt_nxt = pkt_cnt - 1'b1;
      default: pkt_cnt_nxt = pkt_cnt;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (rst_in) pkt_cnt <= '0;
    else        pkt_cnt <= pkt_cnt_nxt;
  end

  assign valid = (count != '0) && (pkt_cnt != '0);
`else
  assign valid = (count != '0);
`endif

  assign bus.fifo_ready_out     = ready;
  assign bus.receiver_valid_out = valid;
  assign bus.receiver_data_out  = head_data;
  assign bus.receiver_last_out  = head_last;
  assign bus.count_out          = count;
  assign bus.almost_full_out    = afull;
endmodule
